// File: rtl/adc_decim_csr_initiator.sv
// ---------------------------------------------------------------------------
// adc_decim_csr_initiator
//
// Purpose:
//   Bridges a host command/response handshake onto the CSR port of the ADC
//   decimator. Each host command is a single CSR write or read. Only one
//   transaction is in flight at a time. A write that is not accepted by the
//   decimator within TIMEOUT_CYCLES cycles is abandoned and reported with
//   an error flag. Every timeout also latches a sticky flag.
//
// Parameters:
//   ADDR_WIDTH      CSR address width
//   CSR_DATA_WIDTH  CSR read/write data width
//   TIMEOUT_CYCLES  maximum cycles a write waits for i_csr_wr_ready (2..65535)
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_cmd_valid / o_cmd_ready    host command handshake
//   i_cmd_write                  1 = write, 0 = read
//   i_cmd_addr, i_cmd_wdata      command address and write data
//   o_rsp_valid / i_rsp_ready    host response handshake
//   o_rsp_rdata, o_rsp_err       response read data (0 for writes), timeout flag
//   o_csr_wr_valid / i_csr_wr_ready  CSR write handshake
//   o_csr_addr, o_csr_wr_data    CSR address and write data (held between accepts)
//   o_csr_rd_ready               one-cycle read strobe; i_csr_rd_data sampled with it
//   i_csr_rd_data                CSR read data
//   o_busy                       transaction in progress
//   o_timeout_sticky             set on any write timeout, cleared by reset only
// ---------------------------------------------------------------------------
module adc_decim_csr_initiator #(
    parameter int ADDR_WIDTH     = 8,
    parameter int CSR_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]     i_cmd_addr,
    input  logic [CSR_DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [CSR_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic                      o_csr_wr_valid,
    output logic [ADDR_WIDTH-1:0]     o_csr_addr,
    output logic [CSR_DATA_WIDTH-1:0] o_csr_wr_data,
    input  logic                      i_csr_wr_ready,
    output logic                      o_csr_rd_ready,
    input  logic [CSR_DATA_WIDTH-1:0] i_csr_rd_data,
    output logic                      o_busy,
    output logic                      o_timeout_sticky
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // A 16-bit timer covers the whole legal TIMEOUT_CYCLES range.
    localparam logic [15:0] TIMER_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t                      state_reg, state_next;
    logic [15:0]                 timer_reg, timer_next;

    logic                        cmd_ready_reg;
    logic                        rsp_valid_reg;
    logic                        csr_wr_valid_reg;
    logic                        csr_rd_ready_reg;
    logic                        busy_reg;
    logic                        rsp_err_reg;
    logic                        timeout_sticky_reg;
    logic [CSR_DATA_WIDTH-1:0]   rsp_rdata_reg;
    logic [ADDR_WIDTH-1:0]       csr_addr_reg;
    logic [CSR_DATA_WIDTH-1:0]   csr_wr_data_reg;

    // Event strobes produced by the next-state logic.
    logic                        cmd_accept;
    logic                        wr_done;
    logic                        wr_timeout;
    logic                        rd_capture;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        cmd_accept = 1'b0;
        wr_done    = 1'b0;
        wr_timeout = 1'b0;
        rd_capture = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // cmd_ready_reg is the registered image of "state is IDLE",
                // held low for the first cycle after reset release.
                if (i_cmd_valid && cmd_ready_reg) begin
                    cmd_accept = 1'b1;
                    timer_next = 16'd0;
                    state_next = i_cmd_write ? ST_WRITE : ST_READ;
                end
            end

            ST_WRITE: begin
                // Ready wins over the limit, so a write accepted on its
                // final allowed cycle still completes without error.
                if (i_csr_wr_ready) begin
                    wr_done    = 1'b1;
                    state_next = ST_RESP;
                end else if (timer_reg == TIMER_LIMIT) begin
                    wr_timeout = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    timer_next = timer_reg + 16'd1;
                end
            end

            ST_READ: begin
                // The strobe is high for exactly this one cycle.
                rd_capture = 1'b1;
                state_next = ST_RESP;
            end

            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, timer and registered outputs. The handshake outputs are decoded
    // from state_next, so each one is a registered copy of the state.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg          <= ST_IDLE;
            timer_reg          <= 16'd0;
            cmd_ready_reg      <= 1'b0;
            rsp_valid_reg      <= 1'b0;
            csr_wr_valid_reg   <= 1'b0;
            csr_rd_ready_reg   <= 1'b0;
            busy_reg           <= 1'b0;
            rsp_err_reg        <= 1'b0;
            timeout_sticky_reg <= 1'b0;
            rsp_rdata_reg      <= '0;
            csr_addr_reg       <= '0;
            csr_wr_data_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            cmd_ready_reg    <= (state_next == ST_IDLE);
            rsp_valid_reg    <= (state_next == ST_RESP);
            csr_wr_valid_reg <= (state_next == ST_WRITE);
            csr_rd_ready_reg <= (state_next == ST_READ);
            busy_reg         <= (state_next != ST_IDLE);

            if (cmd_accept) begin
                csr_addr_reg    <= i_cmd_addr;
                csr_wr_data_reg <= i_cmd_wdata;
                rsp_rdata_reg   <= '0;
                rsp_err_reg     <= 1'b0;
            end

            if (wr_done) begin
                rsp_rdata_reg <= '0;
                rsp_err_reg   <= 1'b0;
            end

            if (wr_timeout) begin
                rsp_rdata_reg      <= '0;
                rsp_err_reg        <= 1'b1;
                timeout_sticky_reg <= 1'b1;
            end

            if (rd_capture) begin
                rsp_rdata_reg <= i_csr_rd_data;
                rsp_err_reg   <= 1'b0;
            end
        end
    end

    assign o_cmd_ready      = cmd_ready_reg;
    assign o_rsp_valid      = rsp_valid_reg;
    assign o_rsp_rdata      = rsp_rdata_reg;
    assign o_rsp_err        = rsp_err_reg;
    assign o_csr_wr_valid   = csr_wr_valid_reg;
    assign o_csr_addr       = csr_addr_reg;
    assign o_csr_wr_data    = csr_wr_data_reg;
    assign o_csr_rd_ready   = csr_rd_ready_reg;
    assign o_busy           = busy_reg;
    assign o_timeout_sticky = timeout_sticky_reg;

endmodule

// File: tb/tb_adc_decim_csr_initiator.sv
// ---------------------------------------------------------------------------
// tb_adc_decim_csr_initiator
//
// Drives host commands into adc_decim_csr_initiator with TIMEOUT_CYCLES=4.
// The expected response of each command is queued when the command is driven.
// A negedge monitor pops and compares it when the response handshake occurs.
// The driver also checks the cycle-by-cycle timing of the CSR strobes.
// ---------------------------------------------------------------------------
module tb_adc_decim_csr_initiator;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_err;
    logic          o_csr_wr_valid;
    logic [AW-1:0] o_csr_addr;
    logic [DW-1:0] o_csr_wr_data;
    logic          i_csr_wr_ready;
    logic          o_csr_rd_ready;
    logic [DW-1:0] i_csr_rd_data;
    logic          o_busy;
    logic          o_timeout_sticky;

    adc_decim_csr_initiator #(
        .ADDR_WIDTH     (AW),
        .CSR_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_cmd_valid      (i_cmd_valid),
        .o_cmd_ready      (o_cmd_ready),
        .i_cmd_write      (i_cmd_write),
        .i_cmd_addr       (i_cmd_addr),
        .i_cmd_wdata      (i_cmd_wdata),
        .o_rsp_valid      (o_rsp_valid),
        .i_rsp_ready      (i_rsp_ready),
        .o_rsp_rdata      (o_rsp_rdata),
        .o_rsp_err        (o_rsp_err),
        .o_csr_wr_valid   (o_csr_wr_valid),
        .o_csr_addr       (o_csr_addr),
        .o_csr_wr_data    (o_csr_wr_data),
        .i_csr_wr_ready   (i_csr_wr_ready),
        .o_csr_rd_ready   (o_csr_rd_ready),
        .i_csr_rd_data    (i_csr_rd_data),
        .o_busy           (o_busy),
        .o_timeout_sticky (o_timeout_sticky)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_exp;
    int   test_cnt = 0;
    int   fail_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after posedge. At negedge a response handshake
    // that completes on the next posedge is already visible.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            check_val("wr_rd_exclusive", {63'd0, o_csr_wr_valid & o_csr_rd_ready}, 64'd0);
            if (o_rsp_valid && i_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_val("rsp_rdata", 64'(o_rsp_rdata), 64'(mon_exp.rdata));
                    check_val("rsp_err", 64'(o_rsp_err), 64'(mon_exp.err));
                end
            end
        end
    end

    // Runs one command from IDLE at posedge+1. The write is given
    // i_csr_wr_ready after rdy_delay stall cycles (>= TO means never).
    // i_rsp_ready is held low for rsp_delay cycles.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] rdv, input int rdy_delay, input int rsp_delay);
        rsp_t e;
        int   n;
        int   wr_cycles;
        e.err   = wr && (rdy_delay >= TO);
        e.rdata = wr ? '0 : rdv;
        check_val("cmd_ready_idle", 64'(o_cmd_ready), 64'd1);
        exp_q.push_back(e);
        i_cmd_valid   = 1'b1;
        i_cmd_write   = wr;
        i_cmd_addr    = addr;
        i_cmd_wdata   = wdata;
        i_csr_rd_data = rdv;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        i_cmd_addr  = AW'($urandom);
        i_cmd_wdata = $urandom;
        check_val("cmd_ready_busy", 64'(o_cmd_ready), 64'd0);
        check_val("busy", 64'(o_busy), 64'd1);
        check_val("csr_addr", 64'(o_csr_addr), 64'(addr));
        wr_cycles = 0;
        if (wr) begin
            n = (rdy_delay < TO) ? rdy_delay + 1 : TO;
            for (int i = 0; i < n; i++) begin
                check_val("wr_valid_on", 64'(o_csr_wr_valid), 64'd1);
                check_val("csr_wr_data", 64'(o_csr_wr_data), 64'(wdata));
                check_val("rd_ready_off", 64'(o_csr_rd_ready), 64'd0);
                check_val("rsp_valid_early", 64'(o_rsp_valid), 64'd0);
                if (o_csr_wr_valid) wr_cycles++;
                if (i == rdy_delay) i_csr_wr_ready = 1'b1;
                @(posedge i_clk); #1;
                i_csr_wr_ready = 1'b0;
            end
            check_val("wr_valid_cycles", 64'(wr_cycles), 64'(n));
            check_val("wr_valid_off", 64'(o_csr_wr_valid), 64'd0);
        end else begin
            check_val("rd_ready_on", 64'(o_csr_rd_ready), 64'd1);
            check_val("wr_valid_off_rd", 64'(o_csr_wr_valid), 64'd0);
            @(posedge i_clk); #1;
            i_csr_rd_data = $urandom;
            check_val("rd_ready_one_cycle", 64'(o_csr_rd_ready), 64'd0);
        end
        check_val("rsp_valid_on", 64'(o_rsp_valid), 64'd1);
        check_val("rsp_rdata_now", 64'(o_rsp_rdata), 64'(e.rdata));
        check_val("rsp_err_now", 64'(o_rsp_err), 64'(e.err));
        for (int i = 0; i < rsp_delay; i++) begin
            @(posedge i_clk); #1;
            check_val("rsp_held_valid", 64'(o_rsp_valid), 64'd1);
            check_val("rsp_held_rdata", 64'(o_rsp_rdata), 64'(e.rdata));
            check_val("rsp_held_err", 64'(o_rsp_err), 64'(e.err));
            check_val("rsp_held_cmd_ready", 64'(o_cmd_ready), 64'd0);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        check_val("rsp_valid_off", 64'(o_rsp_valid), 64'd0);
        check_val("cmd_ready_back", 64'(o_cmd_ready), 64'd1);
        check_val("busy_off", 64'(o_busy), 64'd0);
        check_val("csr_addr_hold", 64'(o_csr_addr), 64'(addr));
        $display("[TB] %s addr=0x%02h wdata=0x%08h rdata=0x%08h err=%0d rdy_delay=%0d rsp_delay=%0d",
                 wr ? "WR" : "RD", addr, wdata, e.rdata, e.err, rdy_delay, rsp_delay);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst          = 1'b1;
        i_cmd_valid    = 1'b0;
        i_cmd_write    = 1'b0;
        i_cmd_addr     = '0;
        i_cmd_wdata    = '0;
        i_rsp_ready    = 1'b0;
        i_csr_wr_ready = 1'b0;
        i_csr_rd_data  = '0;

        repeat (3) @(posedge i_clk);
        #1;
        check_val("rst_cmd_ready", 64'(o_cmd_ready), 64'd0);
        check_val("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check_val("rst_wr_valid", 64'(o_csr_wr_valid), 64'd0);
        check_val("rst_rd_ready", 64'(o_csr_rd_ready), 64'd0);
        check_val("rst_busy", 64'(o_busy), 64'd0);
        check_val("rst_sticky", 64'(o_timeout_sticky), 64'd0);
        check_val("rst_addr", 64'(o_csr_addr), 64'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check_val("cmd_ready_after_rst", 64'(o_cmd_ready), 64'd1);

        // Immediate write, then read.
        run_cmd(1'b1, 8'h10, 32'hA5A5_0001, 32'h0, 0, 0);
        run_cmd(1'b0, 8'h04, 32'h0, 32'h1234_5678, 0, 0);
        // Ready on the final allowed cycle, then 5 cycles of backpressure.
        run_cmd(1'b1, 8'h20, 32'hDEAD_BEEF, 32'h0, TO - 1, 5);
        check_val("sticky_after_late_ready", 64'(o_timeout_sticky), 64'd0);
        // No ready at all, so the write times out.
        run_cmd(1'b1, 8'h30, 32'h0BAD_F00D, 32'h0, 100, 0);
        check_val("sticky_after_timeout", 64'(o_timeout_sticky), 64'd1);

        for (int t = 0; t < 8; t++) begin
            run_cmd(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
        end
        check_val("sticky_holds", 64'(o_timeout_sticky), 64'd1);

        // Reset during a stalled write.
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b1;
        i_cmd_addr  = 8'h55;
        i_cmd_wdata = 32'h5555_AAAA;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        check_val("stall_wr_valid", 64'(o_csr_wr_valid), 64'd1);
        @(posedge i_clk); #1;
        check_val("stall_wr_valid2", 64'(o_csr_wr_valid), 64'd1);
        #3;
        i_rst = 1'b1;
        #1;
        check_val("midrst_wr_valid", 64'(o_csr_wr_valid), 64'd0);
        check_val("midrst_rd_ready", 64'(o_csr_rd_ready), 64'd0);
        check_val("midrst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        check_val("midrst_busy", 64'(o_busy), 64'd0);
        check_val("midrst_sticky", 64'(o_timeout_sticky), 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check_val("cmd_ready_after_midrst", 64'(o_cmd_ready), 64'd1);
        check_val("no_rsp_after_midrst", 64'(o_rsp_valid), 64'd0);
        $display("[TB] RST during write stall addr=0x55");

        run_cmd(1'b0, 8'h08, 32'h0, 32'hCAFE_0042, 0, 1);

        repeat (2) @(posedge i_clk);
        #1;
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
